// File: rtl/fp_addsub_issue.sv
// Issue/retire sequencer wrapped around add_sub_top: unpacks a packed
// operand pair, holds the fields for a settle window, then captures the
// adder's result and returns it with the request tag.
module fp_addsub_issue #(
   parameter int unsigned EXP_BITS      = 8,
   parameter int unsigned SIG_BITS      = 23,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned TAG_BITS      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [EXP_BITS+SIG_BITS:0]   in_op1,
   input  logic [EXP_BITS+SIG_BITS:0]   in_op2,
   input  logic                         in_opcode,
   input  logic [TAG_BITS-1:0]          in_tag,
   output logic                         sign1,
   output logic                         sign2,
   output logic [EXP_BITS-1:0]          exp1,
   output logic [EXP_BITS-1:0]          exp2,
   output logic [SIG_BITS-1:0]          sig1,
   output logic [SIG_BITS-1:0]          sig2,
   output logic                         opcode,
   input  logic [EXP_BITS+SIG_BITS:0]   fp_out,
   input  logic [2:0]                   err_o,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [EXP_BITS+SIG_BITS:0]   out_result,
   output logic [2:0]                   out_err,
   output logic [TAG_BITS-1:0]          out_tag,
   output logic                         busy
);

   localparam int unsigned W     = EXP_BITS + SIG_BITS + 1;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [TAG_BITS-1:0]  tag_q;
   logic                 accept;
   logic                 capture;
   logic                 retire;

   // Next-state and handshake decode; DONE forwards out_ready to in_ready
   // so a retiring result and a new request can share one edge.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      retire    = 1'b0;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) begin
               retire = 1'b1;
               if (in_valid) begin
                  accept    = 1'b1;
                  state_nxt = EXEC;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, settle counter, operand fields and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         tag_q      <= '0;
         sign1      <= 1'b0;
         sign2      <= 1'b0;
         exp1       <= '0;
         exp2       <= '0;
         sig1       <= '0;
         sig2       <= '0;
         opcode     <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_err    <= '0;
         out_tag    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            sign1  <= in_op1[W-1];
            exp1   <= in_op1[W-2 -: EXP_BITS];
            sig1   <= in_op1[SIG_BITS-1:0];
            sign2  <= in_op2[W-1];
            exp2   <= in_op2[W-2 -: EXP_BITS];
            sig2   <= in_op2[SIG_BITS-1:0];
            opcode <= in_opcode;
            tag_q  <= in_tag;
            cnt    <= CNT_W'(SETTLE_CYCLES - 1);
         end else if (state == EXEC && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (capture) begin
            out_valid  <= 1'b1;
            out_result <= fp_out;
            out_err    <= err_o;
            out_tag    <= tag_q;
         end else if (retire) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Scoreboard bench for fp_addsub_issue; a behavioural add_sub_top model
// sits between the unpacked fields and fp_out/err_o.
module tb_fp_addsub_issue;

   localparam int S = 2;
   localparam logic [2:0] ERR_NONE = 3'd0;
   localparam logic [2:0] ERR_NAN  = 3'd1;
   localparam logic [2:0] ERR_OVF  = 3'd2;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  err;
      logic [3:0]  tag;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_opcode, out_valid, out_ready, busy;
   logic [31:0] in_op1, in_op2, fp_out, out_result;
   logic [3:0]  in_tag, out_tag;
   logic        sign1, sign2, opcode;
   logic [7:0]  exp1, exp2;
   logic [22:0] sig1, sig2;
   logic [2:0]  err_o, out_err;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic        b_sign1, b_sign2, b_opcode;
   logic [7:0]  b_exp1, b_exp2;
   logic [22:0] b_sig1, b_sig2;
   logic [31:0] b_fp_out, b_out_result;
   logic [2:0]  b_err_o, b_out_err;
   logic [3:0]  b_out_tag;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   logic prev_valid = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   fp_addsub_issue #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op1(in_op1), .in_op2(in_op2), .in_opcode(in_opcode), .in_tag(in_tag),
      .sign1(sign1), .sign2(sign2), .exp1(exp1), .exp2(exp2),
      .sig1(sig1), .sig2(sig2), .opcode(opcode), .fp_out(fp_out), .err_o(err_o),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_err(out_err), .out_tag(out_tag), .busy(busy));

   fp_addsub_issue #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_op1(in_op1), .in_op2(in_op2), .in_opcode(in_opcode), .in_tag(in_tag),
      .sign1(b_sign1), .sign2(b_sign2), .exp1(b_exp1), .exp2(b_exp2),
      .sig1(b_sig1), .sig2(b_sig2), .opcode(b_opcode), .fp_out(b_fp_out),
      .err_o(b_err_o), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_result(b_out_result), .out_err(b_out_err), .out_tag(b_out_tag),
      .busy(b_busy));

   function automatic real to_real(input logic [31:0] x);
      if (x[30:23] == 8'd0) return x[31] ? -0.0 : 0.0;
      return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
   endfunction

   function automatic logic [34:0] from_real(input real r);
      logic [63:0] d;
      int          e;
      logic [24:0] m;
      logic        g, st;
      d = $realtobits(r);
      if (d[62:52] == 11'd0) return {ERR_NONE, d[63], 31'd0};
      e  = int'(d[62:52]) - 896;
      m  = {2'b01, d[51:29]};
      g  = d[28];
      st = |d[27:0];
      if (g && (st || m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e++;
      end
      if (e >= 255) return {ERR_OVF, d[63], 8'hFF, 23'd0};
      if (e <= 0) return {ERR_NONE, d[63], 31'd0};
      return {ERR_NONE, d[63], e[7:0], m[22:0]};
   endfunction

   // Single-precision add/sub reference: {err, result}.
   function automatic logic [34:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
      logic [31:0] bb;
      logic        a_nan, b_nan, a_inf, b_inf;
      bb    = {b[31] ^ op, b[30:0]};
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      if (a_nan || b_nan) return {ERR_NAN, 32'h7FC00000};
      if (a_inf && b_inf && (a[31] != bb[31])) return {ERR_NAN, 32'h7FC00000};
      if (a_inf) return {ERR_NONE, a};
      if (b_inf) return {ERR_NONE, bb};
      return from_real(to_real(a) + to_real(bb));
   endfunction

   // Behavioural add_sub_top for both instances.
   assign {err_o, fp_out}     = fp_model({sign1, exp1, sig1}, {sign2, exp2, sig2}, opcode);
   assign {b_err_o, b_fp_out} = fp_model({b_sign1, b_exp1, b_sig1},
                                         {b_sign2, b_exp2, b_sig2}, b_opcode);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present a request from a negedge until accepted; returns at the
   // negedge after the accept edge with in_valid dropped.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [3:0] tag, input logic [31:0] er, input logic [2:0] ee,
                        output int waits, output int acc);
      in_op1 = a; in_op2 = b; in_opcode = op; in_tag = tag; in_valid = 1'b1;
      waits = 0;
      acc   = -1;
      #1;
      while (!in_ready && waits < 200) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (!in_ready) begin
         check_eq("issue_timeout", 64'(waits), 64'd0);
      end else begin
         acc = cyc;
         sb.push_back('{res: er, err: ee, tag: tag, acc: cyc});
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      @(negedge clk);
      k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_eq("drain", 64'(sb.size()), 64'd0);
   endtask

   // Retire-side scoreboard: latency on rising out_valid, payload every
   // valid cycle, pop on handshake.
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_result", {60'd0, out_tag}, 64'hFFFF);
            end else begin
               if (!prev_valid) check_eq("latency", 64'(cyc - sb[0].acc), 64'(S + 1));
               check_eq("out_result", out_result, sb[0].res);
               check_eq("out_err", out_err, sb[0].err);
               check_eq("out_tag", out_tag, sb[0].tag);
               check_eq("in_ready_done", in_ready, out_ready);
               if (out_ready) void'(sb.pop_front());
            end
         end
         prev_valid = out_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w, acc, last_acc, n;
      logic [31:0] a, b;
      logic        op;
      logic [34:0] m;

      rst_n = 1'b0; in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_opcode = 1'b0;
      in_tag = '0; out_ready = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_out_result", out_result, 32'd0);
      check_eq("rst_fields", {sign1, exp1, sig1, opcode}, 33'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Add 1.0 + 2.0, with field unpack check.
      issue(32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40400000, ERR_NONE, w, acc);
      #1;
      check_eq("unpack_sign1", sign1, 1'b0);
      check_eq("unpack_exp1", exp1, 8'h7F);
      check_eq("unpack_sig1", sig1, 23'd0);
      check_eq("unpack_exp2", exp2, 8'h80);
      check_eq("unpack_opcode", opcode, 1'b0);
      check_eq("exec_busy", busy, 1'b1);
      check_eq("exec_in_ready", in_ready, 1'b0);
      wait_drain();

      // Subtract 3.0 - 1.0, then inf - inf.
      issue(32'h40400000, 32'h3F800000, 1'b1, 4'd6, 32'h40000000, ERR_NONE, w, acc);
      wait_drain();
      issue(32'h7F800000, 32'h7F800000, 1'b1, 4'd7, 32'h7FC00000, ERR_NAN, w, acc);
      wait_drain();

      // Backpressure, then retire and accept tag 9 on the same edge.
      out_ready = 1'b0;
      issue(32'h40A00000, 32'h3F800000, 1'b0, 4'd3, 32'h40C00000, ERR_NONE, w, acc);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_eq("bp_valid_seen", out_valid, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         check_eq("bp_hold_valid", out_valid, 1'b1);
         check_eq("bp_in_ready", in_ready, 1'b0);
         check_eq("bp_busy", busy, 1'b1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd9, 32'h40000000, ERR_NONE, w, acc);
      check_eq("bp_same_edge_accept", 64'(w), 64'd0);
      wait_drain();

      // Streaming: 16 random requests back to back.
      last_acc = 0;
      for (int t = 0; t < 16; t++) begin
         a  = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
         b  = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
         op = 1'($urandom_range(0, 1));
         m  = fp_model(a, b, op);
         issue(a, b, op, 4'(t), m[31:0], m[34:32], w, acc);
         in_valid = 1'b1;
         if (t > 0) check_eq("stream_period", 64'(acc - last_acc), 64'(S + 1));
         last_acc = acc;
      end
      in_valid = 1'b0;
      wait_drain();

      // Reset while in EXEC discards the request.
      issue(32'h3F800000, 32'h40000000, 1'b0, 4'hC, 32'h40400000, ERR_NONE, w, acc);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_eq("abort_out_valid", out_valid, 1'b0);
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_in_ready", in_ready, 1'b1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check_eq("abort_quiet", out_valid, 1'b0);
      end
      @(negedge clk);
      issue(32'h40000000, 32'h40000000, 1'b0, 4'hD, 32'h40800000, ERR_NONE, w, acc);
      wait_drain();

      // SETTLE_CYCLES=1 instance: accept to out_valid in 2 edges.
      b_in_valid = 1'b1;
      in_op1 = 32'h3F800000; in_op2 = 32'h40000000; in_opcode = 1'b0; in_tag = 4'd2;
      #1;
      check_eq("s1_in_ready", b_in_ready, 1'b1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         b_in_valid = 1'b0;
         n++;
      end while (!b_out_valid && n < 10);
      check_eq("s1_latency", 64'(n), 64'd2);
      check_eq("s1_result", b_out_result, 32'h40400000);
      check_eq("s1_tag", b_out_tag, 4'd2);
      check_eq("s1_err", b_out_err, ERR_NONE);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
